// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage.
// WB bit indices, FSM state enum, MEM/WB bundle struct and bubble value.
package mem_stage_pkg;

  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  rd;
    logic        misalign;
  } mem_wb_t;

  localparam logic [1:0]  WB_BUBBLE   = 2'b00;
  localparam logic [31:0] WORD_ZERO   = 32'h0;
  localparam logic [4:0]  RD_ZERO     = 5'd0;
  localparam mem_wb_t     MEM_WB_BUBBLE = '{
    wb:        WB_BUBBLE,
    read_data: WORD_ZERO,
    alu_out:   WORD_ZERO,
    rd:        RD_ZERO,
    misalign:  1'b0
  };

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB outputs of the MEM stage.
// master = upstream/bench side, slave = mem_stage side.
interface mem_stage_if;

  logic [1:0]  WB_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] ALUOut_i;
  logic [31:0] WriteData_i;
  logic [4:0]  RegRD_i;
  logic        stall_o;
  logic [1:0]  WB_o;
  logic [31:0] ReadData_o;
  logic [31:0] ALUOut_o;
  logic [4:0]  RegRD_o;
  logic        misalign_o;

  modport master (
    output WB_i, MemRead_i, MemWrite_i,
    output ALUOut_i, WriteData_i, RegRD_i,
    input  stall_o, WB_o, ReadData_o,
    input  ALUOut_o, RegRD_o, misalign_o
  );

  modport slave (
    input  WB_i, MemRead_i, MemWrite_i,
    input  ALUOut_i, WriteData_i, RegRD_i,
    output stall_o, WB_o, ReadData_o,
    output ALUOut_o, RegRD_o, misalign_o
  );

endinterface

// File: rtl/mem_stage_data_mem_array.sv
// data_mem_array: DEPTH x 32-bit word store, sync write, sync clear.
// Ports: clk_i, rst_i, we_i, addr_i (word index), wdata_i, rdata_o (comb).
module data_mem_array #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with multi-cycle data-memory access.
// Ports: clk_i, rst_i, bus (mem_stage_if.slave: EX/MEM in, MEM/WB out).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mem_stage_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  mem_wb_t       q;
  mem_wb_t       res;

  logic          mem_op;
  logic          misal;
  logic          start;
  logic          wait_acc;
  logic          we;
  logic [AW-1:0] idx;
  logic [31:0]   rdata;

  assign mem_op = bus.MemRead_i | bus.MemWrite_i;
  assign misal  = |bus.ALUOut_i[1:0];
  assign idx    = bus.ALUOut_i[AW+1:2];

  // Aligned op in IDLE opens a multi-cycle access; misaligned ops
  // and LATENCY==1 complete on the first edge.
  assign start    = (state == IDLE) & mem_op & ~misal
                    & (LATENCY > 1);
  assign wait_acc = (state == ACCESS) & (cnt != CNT_LAST);

  assign bus.stall_o = start | wait_acc;

  assign we = ~bus.stall_o & mem_op & bus.MemWrite_i & ~misal;

  data_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (we),
    .addr_i  (idx),
    .wdata_i (bus.WriteData_i),
    .rdata_o (rdata)
  );

  // Value registered on a completing edge. Read+write together is a
  // store, so it returns no load data.
  always_comb begin
    res           = MEM_WB_BUBBLE;
    res.wb        = bus.WB_i;
    res.alu_out   = bus.ALUOut_i;
    res.rd        = bus.RegRD_i;
    res.misalign  = mem_op & misal;
    if (bus.MemRead_i & ~bus.MemWrite_i & ~misal) begin
      res.read_data = rdata;
    end
    if (mem_op & misal) begin
      res.wb[WB_REGWRITE] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= MEM_WB_BUBBLE;
    end else if (bus.stall_o) begin
      state <= ACCESS;
      cnt   <= cnt + CW'(1);
      q     <= MEM_WB_BUBBLE;
    end else begin
      state <= IDLE;
      cnt   <= '0;
      q     <= res;
    end
  end

  assign bus.WB_o       = q.wb;
  assign bus.ReadData_o = q.read_data;
  assign bus.ALUOut_o   = q.alu_out;
  assign bus.RegRD_o    = q.rd;
  assign bus.misalign_o = q.misalign;

endmodule
